// File: rtl/pipe_sched.sv
// Round-robin issue controller feeding a shared 3-stage
// pipeline that computes f = ((a+b) + (c-d)) * d mod 2^N.
module pipe_sched #(
  parameter int N    = 10,
  parameter int REQS = 4,
  parameter int TW   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REQS-1:0]   req,
  input  logic [REQS*N-1:0] a_bus,
  input  logic [REQS*N-1:0] b_bus,
  input  logic [REQS*N-1:0] c_bus,
  input  logic [REQS*N-1:0] d_bus,
  output logic [REQS-1:0]   gnt,
  output logic [N-1:0]      f,
  output logic [TW-1:0]     out_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        inflight
);

  logic [TW-1:0] ptr_q, ptr_d;
  logic [TW-1:0] win;
  logic          found;
  logic          stall;
  logic          issue;

  logic [N-1:0]  a_w, b_w, c_w, d_w;
  logic [N-1:0]  x1_q, x2_q, d1_q;
  logic [N-1:0]  x1_d, x2_d;
  logic [TW-1:0] t1_q;
  logic          v1_q;
  logic [N-1:0]  x3_q, d2_q, x3_d;
  logic [TW-1:0] t2_q;
  logic          v2_q;
  logic [N-1:0]  f_q, f_d;
  logic [TW-1:0] tag_q;
  logic          ov_q;
  logic [1:0]    infl_q, infl_d;

  assign stall = ov_q & ~out_ready;

  // First set request at or above ptr, wrapping around.
  always_comb begin
    logic [TW-1:0] idx;
    idx   = '0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < REQS; k++) begin
      idx = ptr_q + TW'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (found && !stall && !rst)
      gnt[win] = 1'b1;
  end

  assign issue = |gnt;
  assign ptr_d = issue ? win + TW'(1) : ptr_q;

  assign a_w = a_bus[win*N +: N];
  assign b_w = b_bus[win*N +: N];
  assign c_w = c_bus[win*N +: N];
  assign d_w = d_bus[win*N +: N];

  assign x1_d = a_w + b_w;
  assign x2_d = c_w - d_w;
  assign x3_d = x1_q + x2_q;
  assign f_d  = x3_q * d2_q;

  // A stall freezes every valid bit, so occupancy holds too.
  assign infl_d = stall ? infl_q
                : {1'b0, issue} + {1'b0, v1_q} + {1'b0, v2_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= '0;
      x1_q   <= '0;
      x2_q   <= '0;
      d1_q   <= '0;
      t1_q   <= '0;
      v1_q   <= 1'b0;
      x3_q   <= '0;
      d2_q   <= '0;
      t2_q   <= '0;
      v2_q   <= 1'b0;
      f_q    <= '0;
      tag_q  <= '0;
      ov_q   <= 1'b0;
      infl_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      infl_q <= infl_d;
      if (!stall) begin
        v1_q <= issue;
        if (issue) begin
          x1_q <= x1_d;
          x2_q <= x2_d;
          d1_q <= d_w;
          t1_q <= win;
        end
        x3_q  <= x3_d;
        d2_q  <= d1_q;
        t2_q  <= t1_q;
        v2_q  <= v1_q;
        f_q   <= f_d;
        tag_q <= t2_q;
        ov_q  <= v2_q;
      end
    end
  end

  assign f         = f_q;
  assign out_tag   = tag_q;
  assign out_valid = ov_q;
  assign inflight  = infl_q;

endmodule
